// File: rtl/mmcm_seq_pkg.sv
// Shared encodings and widths for the MMCM lock sequencer.
// state_dbg exposes the raw state value, so the encodings are fixed here
// and must stay stable for anyone decoding ILA captures.
package mmcm_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 3;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } seq_state_t;

    // Lock-loss counter increments but sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        logic [LOSS_W-1:0] r;
        if (v == {LOSS_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + LOSS_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow level signals entering this clock
// domain. Both flops clear to 0 under the synchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// Bring-up sequencer for the 240->480 MHz MMCM: pulses the MMCM reset,
// waits for LOCKED with a timeout and bounded retries, then requires a
// stable lock window before raising sys_ready. Lock loss while running
// restarts the whole sequence. Every output comes straight from a flop.
module mmcm_lock_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 17
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       mmcm_locked,
    output logic       mmcm_reset,
    output logic       sys_ready,
    output logic       lock_fail,
    output logic       lock_lost,
    output logic [2:0] retry_count,
    output logic [7:0] loss_count,
    output logic [2:0] state_dbg
);

    // Terminal counter values for each timed state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK edge that first sees locked_s already counts as one
    // locked sample, so STABLE needs one fewer edge to reach the full window.
    // That is what makes sys_ready rise 2 + LOCK_STABLE_CYCLES edges after
    // mmcm_locked rises.
    localparam int               STABLE_LAST_I = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(STABLE_LAST_I);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

    logic                locked_s;
    seq_state_t          state;
    seq_state_t          next_state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    next_cnt;
    logic [RETRY_W-1:0]  next_retry;
    logic [LOSS_W-1:0]   next_loss;
    logic                lost_evt;

    logic                mmcm_reset_d;
    logic                sys_ready_d;
    logic                lock_fail_d;
    logic                lock_lost_d;

    // LOCKED is asynchronous to clk_in1; only the synchronized copy is used.
    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk   (clk_in1),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (locked_s)
    );

    // State, counters and the registered outputs advance together.
    always_ff @(posedge clk_in1) begin
        if (!reset) begin
            state       <= RESET_HOLD;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
            mmcm_reset  <= 1'b1;
            sys_ready   <= 1'b0;
            lock_fail   <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            retry_count <= next_retry;
            loss_count  <= next_loss;
            mmcm_reset  <= mmcm_reset_d;
            sys_ready   <= sys_ready_d;
            lock_fail   <= lock_fail_d;
            lock_lost   <= lock_lost_d;
        end
    end

    // Next-state, counter, retry and loss bookkeeping from synced lock status.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_retry = retry_count;
        next_loss  = loss_count;
        lost_evt   = 1'b0;
        case (state)
            RESET_HOLD: begin
                if (cnt == RST_LAST) begin
                    next_state = WAIT_LOCK;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock beats a timeout on the same edge.
                if (locked_s) begin
                    next_state = STABLE;
                    next_cnt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_cnt = '0;
                    if (retry_count == RETRY_MAX) begin
                        next_state = FAIL;
                    end else begin
                        next_retry = retry_count + RETRY_ONE;
                        next_state = RESET_HOLD;
                    end
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            STABLE: begin
                // A drop on the final edge still sends us back to WAIT_LOCK.
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    next_cnt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                    next_cnt   = '0;
                    next_retry = '0;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = RESET_HOLD;
                    next_cnt   = '0;
                    next_loss  = sat_inc_loss(loss_count);
                    lost_evt   = 1'b1;
                end
            end
            FAIL: begin
                // Terminal until reset.
            end
            default: begin
                next_state = RESET_HOLD;
                next_cnt   = '0;
            end
        endcase
    end

    // Output values for the upcoming state, registered on the same edge.
    always_comb begin
        mmcm_reset_d = (next_state == RESET_HOLD) || (next_state == FAIL);
        sys_ready_d  = (next_state == RUN);
        lock_fail_d  = (next_state == FAIL);
        lock_lost_d  = lost_evt;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed bench for mmcm_lock_sequencer with a cycle-level reference model.
module tb_mmcm_lock_sequencer;

    localparam int RH = 4;
    localparam int LT = 32;
    localparam int LS = 8;
    localparam int MR = 2;

    logic       clk;
    logic       reset;
    logic       mmcm_locked;
    logic       mmcm_reset;
    logic       sys_ready;
    logic       lock_fail;
    logic       lock_lost;
    logic [2:0] retry_count;
    logic [7:0] loss_count;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    mmcm_lock_sequencer #(
        .RST_HOLD_CYCLES     (RH),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS),
        .MAX_RETRIES         (MR),
        .CNT_W               (17)
    ) dut (
        .clk_in1     (clk),
        .reset       (reset),
        .mmcm_locked (mmcm_locked),
        .mmcm_reset  (mmcm_reset),
        .sys_ready   (sys_ready),
        .lock_fail   (lock_fail),
        .lock_lost   (lock_lost),
        .retry_count (retry_count),
        .loss_count  (loss_count),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: phases hold / acquire / run / dead. In acquire the lock
    // window is a run-length of consecutive synced-locked samples, and the
    // timeout counts consecutive unlocked samples since the last restart.
    localparam int PH_HOLD = 0;
    localparam int PH_ACQ  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DEAD = 3;

    int ph = PH_HOLD;
    int hold_n = 0, idle_n = 0, streak = 0, retries = 0, losses = 0;
    int lost = 0, mvalid = 0;
    int h1 = 0, h2 = 0, ls = 0;

    always @(posedge clk) begin
        if (!reset) begin
            ph = PH_HOLD; hold_n = 0; idle_n = 0; streak = 0;
            retries = 0; losses = 0; lost = 0; h1 = 0; h2 = 0;
            mvalid = 1;
        end else begin
            ls = h2;
            h2 = h1;
            h1 = int'(mmcm_locked);
            lost = 0;
            case (ph)
                PH_HOLD: begin
                    hold_n++;
                    if (hold_n == RH) begin
                        ph = PH_ACQ; idle_n = 0; streak = 0;
                    end
                end
                PH_ACQ: begin
                    if (ls != 0) begin
                        streak++;
                        idle_n = 0;
                        if (streak == LS) begin
                            ph = PH_RUN; retries = 0; streak = 0;
                        end
                    end else if (streak > 0) begin
                        streak = 0; idle_n = 0;
                    end else begin
                        idle_n++;
                        if (idle_n == LT) begin
                            if (retries == MR) begin
                                ph = PH_DEAD;
                            end else begin
                                retries++; ph = PH_HOLD; hold_n = 0;
                            end
                        end
                    end
                end
                PH_RUN: begin
                    if (ls == 0) begin
                        ph = PH_HOLD; hold_n = 0; lost = 1;
                        if (losses < 255) losses++;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every cycle after the first reset edge, all outputs against the model.
    always @(negedge clk) begin
        int exp_dbg;
        if (mvalid != 0) begin
            case (ph)
                PH_HOLD: exp_dbg = 0;
                PH_ACQ:  exp_dbg = (streak > 0) ? 2 : 1;
                PH_RUN:  exp_dbg = 3;
                default: exp_dbg = 4;
            endcase
            check("cyc_mmcm_reset", int'(mmcm_reset), (ph == PH_HOLD || ph == PH_DEAD) ? 1 : 0);
            check("cyc_sys_ready",  int'(sys_ready),  (ph == PH_RUN) ? 1 : 0);
            check("cyc_lock_fail",  int'(lock_fail),  (ph == PH_DEAD) ? 1 : 0);
            check("cyc_lock_lost",  int'(lock_lost),  lost);
            check("cyc_retry",      int'(retry_count), retries);
            check("cyc_loss",       int'(loss_count),  losses);
            check("cyc_state",      int'(state_dbg),   exp_dbg);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, pl, pulses, seen_wait, ready_seen;
        reset = 1'b0;
        mmcm_locked = 1'b0;
        step(3);

        // Reset values
        check("rst_mmcm_reset", int'(mmcm_reset), 1);
        check("rst_sys_ready", int'(sys_ready), 0);
        check("rst_lock_fail", int'(lock_fail), 0);
        check("rst_lock_lost", int'(lock_lost), 0);
        check("rst_retry", int'(retry_count), 0);
        check("rst_loss", int'(loss_count), 0);
        check("rst_state", int'(state_dbg), 0);

        // Clean bring-up
        reset = 1'b1;
        n = 0;
        while (mmcm_reset && n < 50) begin n++; step(1); end
        check("clean_hold_len", n, 4);
        step(10);
        mmcm_locked = 1'b1;
        k = 0;
        while (!sys_ready && k < 50) begin step(1); k++; end
        check("clean_ready_edges", k, 10);
        check("clean_retry", int'(retry_count), 0);
        check("clean_state", int'(state_dbg), 3);

        // Loss in RUN
        mmcm_locked = 1'b0;
        step(1); check("loss_ready_e1", int'(sys_ready), 1);
        step(1); check("loss_ready_e2", int'(sys_ready), 1);
        step(1); check("loss_ready_e3", int'(sys_ready), 0);
        check("loss_pulse_e3", int'(lock_lost), 1);
        check("loss_count1", int'(loss_count), 1);
        n = 0; pl = 0;
        while (mmcm_reset && n < 50) begin
            n++;
            if (lock_lost) pl++;
            step(1);
        end
        check("loss_hold_len", n, 4);
        check("loss_pulse_len", pl, 1);
        mmcm_locked = 1'b1;
        k = 0;
        while (!sys_ready && k < 50) begin step(1); k++; end
        check("loss_relock_edges", k, 10);

        // Glitch during STABLE: the synced drop lands at stable count 5
        reset = 1'b0; mmcm_locked = 1'b0;
        step(2);
        reset = 1'b1;
        n = 0;
        while (mmcm_reset && n < 50) begin n++; step(1); end
        mmcm_locked = 1'b1;
        k = 0;
        while (state_dbg != 3'd2 && k < 20) begin step(1); k++; end
        check("glitch_reach_stable", int'(state_dbg), 2);
        step(3);
        mmcm_locked = 1'b0;
        seen_wait = 0; ready_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (state_dbg == 3'd1) seen_wait = 1;
            if (sys_ready) ready_seen = 1;
        end
        mmcm_locked = 1'b1;
        k = 0;
        while (!sys_ready && k < 50) begin
            step(1); k++;
            if (state_dbg == 3'd1) seen_wait = 1;
        end
        check("glitch_back_to_wait", seen_wait, 1);
        check("glitch_no_early_ready", ready_seen, 0);
        check("glitch_ready_edges", k, 10);
        check("glitch_retry", int'(retry_count), 0);

        // Reset mid-operation at WAIT_LOCK count 20 with one retry used
        reset = 1'b0; mmcm_locked = 1'b0;
        step(2);
        reset = 1'b1;
        k = 0;
        while (retry_count != 3'd1 && k < 100) begin step(1); k++; end
        n = 0;
        while (mmcm_reset && n < 10) begin step(1); n++; end
        step(20);
        check("mid_pre_state", int'(state_dbg), 1);
        check("mid_pre_retry", int'(retry_count), 1);
        reset = 1'b0;
        step(1);
        check("mid_mmcm_reset", int'(mmcm_reset), 1);
        check("mid_retry", int'(retry_count), 0);
        check("mid_state", int'(state_dbg), 0);
        check("mid_sys_ready", int'(sys_ready), 0);
        check("mid_lock_fail", int'(lock_fail), 0);
        check("mid_lock_lost", int'(lock_lost), 0);
        check("mid_loss", int'(loss_count), 0);

        // Never locks: 4 hold, 32 wait, three attempts, then FAIL
        step(1);
        reset = 1'b1;
        for (int c = 0; c < 130; c++) begin
            int er, ec;
            if (c < 4) begin er = 1; ec = 0; end
            else if (c < 36) begin er = 0; ec = 0; end
            else if (c < 40) begin er = 1; ec = 1; end
            else if (c < 72) begin er = 0; ec = 1; end
            else if (c < 76) begin er = 1; ec = 2; end
            else if (c < 108) begin er = 0; ec = 2; end
            else begin er = 1; ec = 2; end
            check("never_mmcm_reset", int'(mmcm_reset), er);
            check("never_retry", int'(retry_count), ec);
            if (c >= 108) begin
                check("never_fail", int'(lock_fail), 1);
                check("never_state", int'(state_dbg), 4);
                check("never_ready", int'(sys_ready), 0);
            end
            step(1);
        end
        reset = 1'b0;
        step(1);
        check("fail_reset_state", int'(state_dbg), 0);
        check("fail_reset_flag", int'(lock_fail), 0);

        // Saturation: 260 lock losses
        reset = 1'b1; mmcm_locked = 1'b1;
        k = 0;
        while (!sys_ready && k < 60) begin step(1); k++; end
        pulses = 0;
        for (int e = 0; e < 260; e++) begin
            mmcm_locked = 1'b0;
            n = 0;
            while (!lock_lost && n < 8) begin step(1); n++; end
            if (lock_lost) pulses++;
            mmcm_locked = 1'b1;
            k = 0;
            while (!sys_ready && k < 40) begin step(1); k++; end
        end
        check("sat_pulses", pulses, 260);
        check("sat_loss", int'(loss_count), 255);
        check("sat_ready", int'(sys_ready), 1);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
